// File: rtl/harq_llr_combiner_if.sv
// RDM LLR stream and HARQ soft-buffer RAM port bundle of the HARQ LLR combiner.
// master = combiner side, slave = RDM source plus HARQ RAM side.
interface harq_llr_combiner_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_W     = 96
);
  logic                  o_RDM_Data_Request;
  logic                  i_RDM_Data_Valid;
  logic                  i_RDM_Data_Comp;
  logic [DATA_W-1:0]     i_RDM_Data_Content;
  logic [ADDR_WIDTH-1:0] o_HARQ_Rd_Address;
  logic [DATA_W-1:0]     i_HARQ_Rd_Data;
  logic                  o_HARQ_Wr_Enable;
  logic [ADDR_WIDTH-1:0] o_HARQ_Wr_Address;
  logic [DATA_W-1:0]     o_HARQ_Wr_Data;

  modport master (
    output o_RDM_Data_Request,
    input  i_RDM_Data_Valid,
    input  i_RDM_Data_Comp,
    input  i_RDM_Data_Content,
    output o_HARQ_Rd_Address,
    input  i_HARQ_Rd_Data,
    output o_HARQ_Wr_Enable,
    output o_HARQ_Wr_Address,
    output o_HARQ_Wr_Data
  );

  modport slave (
    input  o_RDM_Data_Request,
    output i_RDM_Data_Valid,
    output i_RDM_Data_Comp,
    output i_RDM_Data_Content,
    input  o_HARQ_Rd_Address,
    output i_HARQ_Rd_Data,
    input  o_HARQ_Wr_Enable,
    input  o_HARQ_Wr_Address,
    input  o_HARQ_Wr_Data
  );
endinterface

// File: rtl/harq_llr_combiner.sv
// HARQ LLR combiner: streams RDM words, adds them lane-wise with saturation to the
// matching HARQ soft-buffer word and writes the result back in place.
module harq_llr_combiner #(
  parameter int LLR_WIDTH  = 6,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                i_core_clk,
  input  logic                i_rx_rstn,
  input  logic                i_Combine_process_request,
  input  logic [15:0]         i_Current_Combine_Ncb_Size,
  input  logic                i_Combine_first_tx,
  output logic                o_Combine_Busy,
  output logic                o_Combine_Done,
  output logic                o_Combine_Underrun,
  harq_llr_combiner_if.master bus
);

  localparam int DATA_W    = LLR_WIDTH * LANES;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int CNT_W     = 13;
  localparam logic signed [LLR_WIDTH:0] SAT_MAX = (LLR_WIDTH+1)'((1 << (LLR_WIDTH-1)) - 1);
  localparam logic signed [LLR_WIDTH:0] SAT_MIN = -SAT_MAX;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Symmetric clip: the most negative code is never written back.
  function automatic logic [LLR_WIDTH-1:0] sat_llr(input logic signed [LLR_WIDTH:0] s);
    if (s > SAT_MAX)      sat_llr = SAT_MAX[LLR_WIDTH-1:0];
    else if (s < SAT_MIN) sat_llr = SAT_MIN[LLR_WIDTH-1:0];
    else                  sat_llr = s[LLR_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] combine_word(
    input logic [DATA_W-1:0]    rdm,
    input logic [DATA_W-1:0]    harq,
    input logic                 first_tx,
    input logic                 last,
    input logic [LANE_BITS-1:0] tail
  );
    logic [LLR_WIDTH-1:0]        r;
    logic [LLR_WIDTH-1:0]        h;
    logic signed [LLR_WIDTH:0]   s;
    combine_word = '0;
    for (int k = 0; k < LANES; k++) begin
      r = rdm[k*LLR_WIDTH +: LLR_WIDTH];
      h = harq[k*LLR_WIDTH +: LLR_WIDTH];
      s = first_tx ? {r[LLR_WIDTH-1], r} : {r[LLR_WIDTH-1], r} + {h[LLR_WIDTH-1], h};
      if (last && (tail != '0) && (k >= int'(tail)))
        combine_word[k*LLR_WIDTH +: LLR_WIDTH] = h;
      else
        combine_word[k*LLR_WIDTH +: LLR_WIDTH] = sat_llr(s);
    end
  endfunction

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      w_q, w_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [LANE_BITS-1:0]  tail_q, tail_d;
  logic                  first_q, first_d;
  logic                  underrun_q, underrun_d;
  logic                  accept;
  logic                  pipe_busy;

  logic                  vld_p0_q  [RD_LATENCY];
  logic                  vld_p0_d  [RD_LATENCY];
  logic [DATA_W-1:0]     data_p0_q [RD_LATENCY];
  logic [DATA_W-1:0]     data_p0_d [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_p0_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_p0_d [RD_LATENCY];
  logic                  last_p0_q [RD_LATENCY];
  logic                  last_p0_d [RD_LATENCY];

  logic                  wr_vld_p1_q, wr_vld_p1_d;
  logic [ADDR_WIDTH-1:0] wr_addr_p1_q, wr_addr_p1_d;
  logic [DATA_W-1:0]     wr_data_p1_q, wr_data_p1_d;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    n_d        = n_q;
    tail_d     = tail_q;
    first_d    = first_q;
    underrun_d = underrun_q;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Combine_process_request) begin
          n_d        = CNT_W'(i_Current_Combine_Ncb_Size[15:LANE_BITS])
                     + CNT_W'(|i_Current_Combine_Ncb_Size[LANE_BITS-1:0]);
          tail_d     = i_Current_Combine_Ncb_Size[LANE_BITS-1:0];
          first_d    = i_Combine_first_tx;
          underrun_d = 1'b0;
          w_d        = '0;
          state_d    = (i_Current_Combine_Ncb_Size == 16'd0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: state_d = ST_RECV;
      ST_RECV: begin
        accept = bus.i_RDM_Data_Valid && (w_q < n_q);
        if (accept) w_d = w_q + 1'b1;
        // Completion wins over Comp when the Nth word and Comp coincide.
        if (w_d == n_q) begin
          state_d = ST_DRAIN;
        end else if (bus.i_RDM_Data_Comp) begin
          state_d    = ST_DRAIN;
          underrun_d = 1'b1;
        end
      end
      ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage p0: delay accepted words to line up with the HARQ read data.
  always_comb begin
    vld_p0_d[0]  = accept;
    data_p0_d[0] = bus.i_RDM_Data_Content;
    addr_p0_d[0] = w_q[ADDR_WIDTH-1:0];
    last_p0_d[0] = (w_q == n_q - 1'b1);
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_p0_d[i]  = vld_p0_q[i-1];
      data_p0_d[i] = data_p0_q[i-1];
      addr_p0_d[i] = addr_p0_q[i-1];
      last_p0_d[i] = last_p0_q[i-1];
    end
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) pipe_busy = pipe_busy | vld_p0_q[i];
  end

  // Stage p1: lane-wise combine and registered write port.
  always_comb begin
    wr_vld_p1_d  = vld_p0_q[RD_LATENCY-1];
    wr_addr_p1_d = wr_addr_p1_q;
    wr_data_p1_d = wr_data_p1_q;
    if (vld_p0_q[RD_LATENCY-1]) begin
      wr_addr_p1_d = addr_p0_q[RD_LATENCY-1];
      wr_data_p1_d = combine_word(data_p0_q[RD_LATENCY-1], bus.i_HARQ_Rd_Data,
                                  first_q, last_p0_q[RD_LATENCY-1], tail_q);
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      n_q          <= '0;
      tail_q       <= '0;
      first_q      <= 1'b0;
      underrun_q   <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) vld_p0_q[i] <= 1'b0;
      wr_vld_p1_q  <= 1'b0;
      wr_addr_p1_q <= '0;
      wr_data_p1_q <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      n_q          <= n_d;
      tail_q       <= tail_d;
      first_q      <= first_d;
      underrun_q   <= underrun_d;
      for (int i = 0; i < RD_LATENCY; i++) vld_p0_q[i] <= vld_p0_d[i];
      wr_vld_p1_q  <= wr_vld_p1_d;
      wr_addr_p1_q <= wr_addr_p1_d;
      wr_data_p1_q <= wr_data_p1_d;
    end
  end

  always_ff @(posedge i_core_clk) begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      data_p0_q[i] <= data_p0_d[i];
      addr_p0_q[i] <= addr_p0_d[i];
      last_p0_q[i] <= last_p0_d[i];
    end
  end

  assign o_Combine_Busy         = (state_q != ST_IDLE);
  assign o_Combine_Done         = (state_q == ST_DONE);
  assign o_Combine_Underrun     = underrun_q;
  assign bus.o_RDM_Data_Request = (state_q == ST_REQ);
  assign bus.o_HARQ_Rd_Address  = w_q[ADDR_WIDTH-1:0];
  assign bus.o_HARQ_Wr_Enable   = wr_vld_p1_q;
  assign bus.o_HARQ_Wr_Address  = wr_addr_p1_q;
  assign bus.o_HARQ_Wr_Data     = wr_data_p1_q;

endmodule

// File: tb/tb_harq_llr_combiner.sv
// Directed bench for harq_llr_combiner: table of single-word combine jobs plus
// hand-written multi-word, gap, underrun, reset and empty-job sequences.
module tb_harq_llr_combiner;
  localparam int AW = 12;
  localparam int DW = 96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ncb = '0;
  logic        first_tx = 1'b0;
  logic        busy, done, underrun;

  harq_llr_combiner_if #(.ADDR_WIDTH(AW), .DATA_W(DW)) bus ();

  harq_llr_combiner #(.LLR_WIDTH(6), .LANES(16), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .i_core_clk                 (clk),
    .i_rx_rstn                  (rst_n),
    .i_Combine_process_request  (start),
    .i_Current_Combine_Ncb_Size (ncb),
    .i_Combine_first_tx         (first_tx),
    .o_Combine_Busy             (busy),
    .o_Combine_Done             (done),
    .o_Combine_Underrun         (underrun),
    .bus                        (bus)
  );

  always #5 clk = ~clk;

  // HARQ RAM model, one cycle read latency; contents preloaded by the test.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) bus.i_HARQ_Rd_Data <= mem[bus.o_HARQ_Rd_Address[5:0]];

  int cyc = 0, n_wr = 0, n_req = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wr_addr_log [0:255];
  logic [DW-1:0] wr_data_log [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_HARQ_Wr_Enable) begin
      wr_addr_log[n_wr[7:0]] <= bus.o_HARQ_Wr_Address;
      wr_data_log[n_wr[7:0]] <= bus.o_HARQ_Wr_Data;
      n_wr        <= n_wr + 1;
      last_wr_cyc <= cyc;
    end
    if (bus.o_RDM_Data_Request) n_req <= n_req + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [5:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*6 +: 6] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] mix(input logic [5:0] lo, input logic [5:0] hi, input int tail);
    logic [DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*6 +: 6] = (k < tail) ? lo : hi;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n, input logic f);
    start = 1'b1; ncb = n; first_tx = f;
    tick();
    start = 1'b0;
    tick();
  endtask

  logic [DW-1:0] rdm_words [0:7];

  // comp_mode: 0 none, 1 Comp with the last word sent, 2 Comp one cycle after it.
  task automatic send_words(input int nsend, input int gap, input int comp_mode);
    for (int i = 0; i < nsend; i++) begin
      bus.i_RDM_Data_Valid   = 1'b1;
      bus.i_RDM_Data_Content = rdm_words[i];
      bus.i_RDM_Data_Comp    = (comp_mode == 1) && (i == nsend - 1);
      tick();
      bus.i_RDM_Data_Valid = 1'b0;
      bus.i_RDM_Data_Comp  = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    if (comp_mode == 2) begin
      bus.i_RDM_Data_Comp = 1'b1;
      tick();
      bus.i_RDM_Data_Comp = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int t = 0; t < 60 && n_done == d0; t++) tick();
    repeat (3) tick();
    check_eq({name, "_done_pulses"}, n_done - d0, 1);
    check_eq({name, "_busy_after"}, busy, 1'b0);
  endtask

  typedef struct {
    logic       first;
    logic [5:0] rdm;
    logic [5:0] harq;
    logic [5:0] exp;
  } vec_t;

  vec_t vec [0:10];
  int   w0, d0, r0, sc;

  initial begin
    // Lane values in two's complement 6-bit hex: 0x31=-15 0x2C=-20 0x20=-32 0x21=-31
    // 0x3D=-3 0x3B=-5 0x3E=-2.
    vec[0]  = '{1'b1, 6'h05, 6'h0A, 6'h05};  // first tx ignores HARQ
    vec[1]  = '{1'b0, 6'h0F, 6'h14, 6'h1F};  // 15+20 -> +31
    vec[2]  = '{1'b0, 6'h31, 6'h2C, 6'h21};  // -15-20 -> -31
    vec[3]  = '{1'b0, 6'h20, 6'h00, 6'h21};  // -32+0 -> -31
    vec[4]  = '{1'b1, 6'h20, 6'h07, 6'h21};  // first tx -32 -> -31
    vec[5]  = '{1'b0, 6'h0A, 6'h3D, 6'h07};  // 10-3 = 7
    vec[6]  = '{1'b0, 6'h1F, 6'h1F, 6'h1F};  // 31+31 -> +31
    vec[7]  = '{1'b0, 6'h20, 6'h20, 6'h21};  // -64 -> -31
    vec[8]  = '{1'b0, 6'h3B, 6'h03, 6'h3E};  // -5+3 = -2
    vec[9]  = '{1'b0, 6'h00, 6'h00, 6'h00};
    vec[10] = '{1'b0, 6'h1F, 6'h21, 6'h00};  // 31-31 = 0

    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.i_RDM_Data_Valid   = 1'b0;
    bus.i_RDM_Data_Comp    = 1'b0;
    bus.i_RDM_Data_Content = '0;

    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_req", bus.o_RDM_Data_Request, 1'b0);
    check_eq("rst_wr_en", bus.o_HARQ_Wr_Enable, 1'b0);
    check_eq("rst_rd_addr", bus.o_HARQ_Rd_Address, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      mem[0] = fill(vec[v].harq);
      rdm_words[0] = fill(vec[v].rdm);
      w0 = n_wr; d0 = n_done;
      start_job(16'd16, vec[v].first);
      send_words(1, 0, 0);
      wait_done(d0, $sformatf("vec%0d", v));
      check_eq($sformatf("vec%0d_nwr", v), n_wr - w0, 1);
      check_eq($sformatf("vec%0d_addr", v), wr_addr_log[w0[7:0]], 0);
      check_eq($sformatf("vec%0d_data", v), wr_data_log[w0[7:0]], fill(vec[v].exp));
    end

    // Ncb=32, saturating both ways; Comp arrives together with the 2nd (last) word.
    mem[0] = fill(6'h14); mem[1] = fill(6'h2C);
    rdm_words[0] = fill(6'h0F); rdm_words[1] = fill(6'h31);
    w0 = n_wr; d0 = n_done;
    start_job(16'd32, 1'b0);
    send_words(2, 0, 1);
    wait_done(d0, "sat2");
    check_eq("sat2_nwr", n_wr - w0, 2);
    check_eq("sat2_data0", wr_data_log[w0[7:0]], fill(6'h1F));
    check_eq("sat2_data1", wr_data_log[(w0 + 1) & 255], fill(6'h21));
    check_eq("sat2_underrun", underrun, 1'b0);

    // Ncb=64 first tx, four back-to-back words of lane value 5.
    for (int i = 0; i < 4; i++) rdm_words[i] = fill(6'h05);
    w0 = n_wr; d0 = n_done; r0 = n_req;
    start_job(16'd64, 1'b1);
    send_words(4, 0, 0);
    wait_done(d0, "b2b");
    check_eq("b2b_req", n_req - r0, 1);
    check_eq("b2b_nwr", n_wr - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("b2b_addr%0d", i), wr_addr_log[(w0 + i) & 255], i);
      check_eq($sformatf("b2b_data%0d", i), wr_data_log[(w0 + i) & 255], fill(6'h05));
    end
    check_eq("b2b_done_after_wr", done_cyc - last_wr_cyc, 1);
    check_eq("b2b_underrun", underrun, 1'b0);

    // Ncb=40: three words, the last one only 8 lanes wide.
    for (int i = 0; i < 3; i++) begin mem[i] = fill(6'h04); rdm_words[i] = fill(6'h03); end
    w0 = n_wr; d0 = n_done;
    start_job(16'd40, 1'b0);
    send_words(3, 0, 0);
    wait_done(d0, "tail");
    check_eq("tail_nwr", n_wr - w0, 3);
    check_eq("tail_data0", wr_data_log[w0[7:0]], fill(6'h07));
    check_eq("tail_data1", wr_data_log[(w0 + 1) & 255], fill(6'h07));
    check_eq("tail_data2", wr_data_log[(w0 + 2) & 255], mix(6'h07, 6'h04, 8));
    check_eq("tail_addr2", wr_addr_log[(w0 + 2) & 255], 2);

    // Ncb=48, valid every other cycle, one extra word past the end.
    for (int i = 0; i < 4; i++) rdm_words[i] = fill(6'(i + 1));
    w0 = n_wr; d0 = n_done;
    start_job(16'd48, 1'b1);
    send_words(4, 1, 0);
    wait_done(d0, "gap");
    check_eq("gap_nwr", n_wr - w0, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("gap_addr%0d", i), wr_addr_log[(w0 + i) & 255], i);
      check_eq($sformatf("gap_data%0d", i), wr_data_log[(w0 + i) & 255], fill(6'(i + 1)));
    end

    // Ncb=64, Comp after two words: early end of stream.
    for (int i = 0; i < 2; i++) rdm_words[i] = fill(6'h09);
    w0 = n_wr; d0 = n_done;
    start_job(16'd64, 1'b1);
    send_words(2, 0, 2);
    wait_done(d0, "under");
    check_eq("under_nwr", n_wr - w0, 2);
    check_eq("under_flag", underrun, 1'b1);

    // Next start clears underrun; reset one word into the job stops everything.
    rdm_words[0] = fill(6'h05);
    start_job(16'd64, 1'b1);
    check_eq("under_cleared", underrun, 1'b0);
    send_words(1, 0, 0);
    w0 = n_wr;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_wr_en", bus.o_HARQ_Wr_Enable, 1'b0);
    check_eq("mid_rst_wr_addr", bus.o_HARQ_Wr_Address, 0);
    check_eq("mid_rst_wr_data", bus.o_HARQ_Wr_Data, 0);
    check_eq("mid_rst_rd_addr", bus.o_HARQ_Rd_Address, 0);
    repeat (3) tick();
    check_eq("mid_rst_no_write", n_wr - w0, 0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_rst_idle", busy, 1'b0);

    // Ncb=0: DONE directly from IDLE, no request.
    d0 = n_done; r0 = n_req; sc = cyc;
    start = 1'b1; ncb = 16'd0; first_tx = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check_eq("zero_done_pulses", n_done - d0, 1);
    check_eq("zero_done_cycle", done_cyc - sc, 1);
    check_eq("zero_no_req", n_req - r0, 0);
    check_eq("zero_busy_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
